// File: rtl/des_ctrl_pkg.sv
// rtl/des_ctrl_pkg.sv - shared state encoding and block width for the DES block sequencer
package des_ctrl_pkg;

    localparam int BLK_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_OUT   = 2'd3
    } des_state_e;

endpackage

// File: rtl/des_ctrl_wdog.sv
// rtl/des_ctrl_wdog.sv - coprocessor completion watchdog, present only with DES_CTRL_TIMEOUT_EN
`ifdef DES_CTRL_TIMEOUT_EN
module des_ctrl_wdog #(
    parameter int TMO_CYC = 64
) (
    input  logic hclk,
    input  logic hresetn,
    input  logic start,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TMO_CYC + 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (run) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // The cycle holding count TMO_CYC-1 is the last of TMO_CYC waiting cycles.
    assign expire = run && (cnt_q == CW'(TMO_CYC - 1));

endmodule
`endif

// File: rtl/des_blk_ctrl.sv
// rtl/des_blk_ctrl.sv - DES/TDES block sequencer with CBC chaining; DES_CTRL_TIMEOUT_EN adds a completion timeout
module des_blk_ctrl
    import des_ctrl_pkg::*;
#(
`ifdef DES_CTRL_TIMEOUT_EN
    parameter int TMO_CYC = 64,
`endif
    parameter int CNT_W   = 16
) (
    input  logic             hclk,
    input  logic             hresetn,
    input  logic             cfg_start,
    input  logic [BLK_W-1:0] cfg_iv,
    input  logic             cfg_cbc,
    input  logic             cfg_decrypt,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [BLK_W-1:0] s_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [BLK_W-1:0] m_data,
    output logic [BLK_W-1:0] cop_din,
    output logic             cop_din_valid,
    output logic             cop_encrypt,
    output logic             cop_mode_sel,
    output logic             cop_iv_sel,
    output logic [BLK_W-1:0] cop_iv,
    input  logic [BLK_W-1:0] cop_dout,
    input  logic             cop_dout_valid,
    output logic             busy,
    output logic [CNT_W-1:0] blk_cnt,
    output logic             err
);

    des_state_e       state_q, state_nxt;
    logic [BLK_W-1:0] din_q, iv_q, m_data_q;
    logic             cbc_q, dec_q;
    logic [CNT_W-1:0] cnt_q;
    logic             tmo_expire;

`ifdef DES_CTRL_TIMEOUT_EN
    logic err_q;

    des_ctrl_wdog #(.TMO_CYC(TMO_CYC)) u_wdog (
        .hclk    (hclk),
        .hresetn (hresetn),
        .start   (state_q == ST_ISSUE),
        .run     (state_q == ST_WAIT),
        .expire  (tmo_expire)
    );

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            err_q <= 1'b0;
        end else if (state_q == ST_IDLE && cfg_start) begin
            err_q <= 1'b0;
        end else if (state_q == ST_WAIT && !cop_dout_valid && tmo_expire) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign tmo_expire = 1'b0;
    assign err        = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:  if (s_valid) state_nxt = ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (cop_dout_valid)  state_nxt = ST_OUT;
                else if (tmo_expire) state_nxt = ST_IDLE;
            end
            ST_OUT:   if (m_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q  <= ST_IDLE;
            din_q    <= '0;
            iv_q     <= '0;
            m_data_q <= '0;
            cbc_q    <= 1'b0;
            dec_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q <= state_nxt;
            case (state_q)
                ST_IDLE: begin
                    // Config is latched before the block is issued, so a same-cycle block uses it.
                    if (cfg_start) begin
                        iv_q  <= cfg_iv;
                        cbc_q <= cfg_cbc;
                        dec_q <= cfg_decrypt;
                        cnt_q <= '0;
                    end
                    if (s_valid) din_q <= s_data;
                end
                ST_WAIT: begin
                    if (cop_dout_valid) begin
                        m_data_q <= cop_dout;
                        if (cbc_q) iv_q <= dec_q ? din_q : cop_dout;
                    end
                end
                ST_OUT: begin
                    if (m_ready) cnt_q <= cnt_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign s_ready       = (state_q == ST_IDLE);
    assign m_valid       = (state_q == ST_OUT);
    assign cop_din_valid = (state_q == ST_ISSUE);
    assign busy          = (state_q != ST_IDLE);
    assign m_data        = m_data_q;
    assign cop_din       = din_q;
    assign cop_iv        = iv_q;
    assign cop_encrypt   = dec_q;
    assign cop_mode_sel  = cbc_q;
    assign cop_iv_sel    = cbc_q;
    assign blk_cnt       = cnt_q;

endmodule

// File: tb/tb_des_blk_ctrl.sv
// tb/tb_des_blk_ctrl.sv - directed self-checking bench for des_blk_ctrl with a toy invertible coprocessor model
module tb_des_blk_ctrl;

    localparam logic [63:0] PT  = 64'h0123456789ABCDEF;
    localparam logic [63:0] CT  = 64'h85E813540F0AB405;
    localparam logic [63:0] KX  = 64'hA6AD74DDA4C75B04;
    localparam logic [63:0] CB2 = 64'h6DFB475B05BEB180;
    localparam logic [63:0] CB3 = 64'h7EAF4851B1BB3468;

    logic        hclk = 1'b0;
    logic        hresetn = 1'b0;
    logic        cfg_start = 1'b0;
    logic [63:0] cfg_iv = '0;
    logic        cfg_cbc = 1'b0;
    logic        cfg_decrypt = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [63:0] m_data;
    logic [63:0] cop_din;
    logic        cop_din_valid;
    logic        cop_encrypt;
    logic        cop_mode_sel;
    logic        cop_iv_sel;
    logic [63:0] cop_iv;
    logic [63:0] cop_dout = '0;
    logic        cop_dout_valid = 1'b0;
    logic        busy;
    logic [15:0] blk_cnt;
    logic        err;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int cop_lat = 4;
    bit cop_mute = 1'b0;

    des_blk_ctrl dut (
        .hclk(hclk), .hresetn(hresetn),
        .cfg_start(cfg_start), .cfg_iv(cfg_iv), .cfg_cbc(cfg_cbc), .cfg_decrypt(cfg_decrypt),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .cop_din(cop_din), .cop_din_valid(cop_din_valid), .cop_encrypt(cop_encrypt),
        .cop_mode_sel(cop_mode_sel), .cop_iv_sel(cop_iv_sel), .cop_iv(cop_iv),
        .cop_dout(cop_dout), .cop_dout_valid(cop_dout_valid),
        .busy(busy), .blk_cnt(blk_cnt), .err(err)
    );

    always #5 hclk = ~hclk;

    // Toy cipher: E(x) = rotl8(x) ^ KX, chosen so that E(PT) == CT.
    function automatic logic [63:0] toy_enc(input logic [63:0] x);
        return {x[55:0], x[63:56]} ^ KX;
    endfunction

    function automatic logic [63:0] toy_dec(input logic [63:0] y);
        logic [63:0] t;
        t = y ^ KX;
        return {t[7:0], t[63:8]};
    endfunction

    bit          cop_pend = 1'b0;
    int          cop_left = 0;
    logic [63:0] cop_res = '0;

    always @(posedge hclk) begin
        cop_dout_valid <= 1'b0;
        if (cop_din_valid) begin
            pulses   <= pulses + 1;
            cop_pend <= 1'b1;
            cop_left <= cop_lat;
            if (cop_mode_sel)
                cop_res <= cop_encrypt ? (toy_dec(cop_din) ^ cop_iv) : toy_enc(cop_din ^ cop_iv);
            else
                cop_res <= cop_encrypt ? toy_dec(cop_din) : toy_enc(cop_din);
        end else if (cop_pend) begin
            if (cop_left == 0) begin
                cop_pend <= 1'b0;
                if (!cop_mute) begin
                    cop_dout_valid <= 1'b1;
                    cop_dout       <= cop_res;
                end
            end else begin
                cop_left <= cop_left - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic do_cfg(input logic [63:0] iv, input logic cbc, input logic dec);
        @(negedge hclk);
        cfg_start = 1'b1; cfg_iv = iv; cfg_cbc = cbc; cfg_decrypt = dec;
        @(negedge hclk);
        cfg_start = 1'b0;
    endtask

    task automatic wait_m_valid(input string tag);
        int n;
        n = 0;
        while (!m_valid && n < 300) begin
            @(negedge hclk);
            n++;
        end
        if (!m_valid) chk({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic run_block(input string tag, input logic [63:0] din, output logic [63:0] dout);
        @(negedge hclk);
        s_valid = 1'b1; s_data = din; m_ready = 1'b1;
        @(negedge hclk);
        s_valid = 1'b0;
        wait_m_valid(tag);
        dout = m_data;
        @(negedge hclk);
        m_ready = 1'b0;
    endtask

    logic [63:0] r;
    int          p0;
    int          n;

    initial begin
        repeat (3) @(negedge hclk);
        chk("rst_s_ready", 64'(s_ready), 64'd1);
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_din_valid", 64'(cop_din_valid), 64'd0);
        chk("rst_outs", {m_data ^ cop_din ^ cop_iv}, 64'd0);
        chk("rst_misc", 64'({busy, err, blk_cnt, cop_encrypt, cop_mode_sel, cop_iv_sel}), 64'd0);
        hresetn = 1'b1;

        // 1: ECB encrypt
        do_cfg(64'd0, 1'b0, 1'b0);
        p0 = pulses;
        run_block("ecb_enc", PT, r);
        chk("ecb_enc_data", r, CT);
        chk("ecb_enc_cnt", 64'(blk_cnt), 64'd1);
        chk("ecb_enc_pulses", 64'(pulses - p0), 64'd1);
        chk("ecb_enc_iv", cop_iv, 64'd0);

        // 2: ECB decrypt, config and block presented in the same IDLE cycle
        @(negedge hclk);
        cfg_start = 1'b1; cfg_iv = 64'd0; cfg_cbc = 1'b0; cfg_decrypt = 1'b1;
        s_valid = 1'b1; s_data = CT; m_ready = 1'b1;
        @(negedge hclk);
        cfg_start = 1'b0; s_valid = 1'b0;
        wait_m_valid("ecb_dec");
        chk("ecb_dec_data", m_data, PT);
        chk("ecb_dec_dir", 64'(cop_encrypt), 64'd1);
        @(negedge hclk);
        m_ready = 1'b0;
        chk("ecb_dec_cnt", 64'(blk_cnt), 64'd1);

        // 3: CBC encrypt then decrypt, zero IV
        do_cfg(64'd0, 1'b1, 1'b0);
        run_block("cbc_e1", PT, r);
        chk("cbc_e1_data", r, CT);
        chk("cbc_e1_iv", cop_iv, CT);
        chk("cbc_sel", 64'({cop_mode_sel, cop_iv_sel}), 64'd3);
        run_block("cbc_e2", PT, r);
        chk("cbc_e2_data", r, CB2);
        run_block("cbc_e3", PT, r);
        chk("cbc_e3_data", r, CB3);
        chk("cbc_e_cnt", 64'(blk_cnt), 64'd3);
        do_cfg(64'd0, 1'b1, 1'b1);
        run_block("cbc_d1", CT, r);
        chk("cbc_d1_data", r, PT);
        chk("cbc_d1_iv", cop_iv, CT);
        run_block("cbc_d2", CB2, r);
        chk("cbc_d2_data", r, PT);
        run_block("cbc_d3", CB3, r);
        chk("cbc_d3_data", r, PT);
        chk("cbc_d3_iv", cop_iv, CB3);

        // 4: output stall holds the result and blocks new input
        do_cfg(64'd0, 1'b0, 1'b0);
        @(negedge hclk);
        s_valid = 1'b1; s_data = PT; m_ready = 1'b0;
        @(negedge hclk);
        s_data = CT;
        wait_m_valid("stall");
        p0 = pulses;
        for (int i = 0; i < 20; i++) begin
            chk("stall_hold", {m_valid, s_ready, m_data[61:0]}, {1'b1, 1'b0, CT[61:0]});
            @(negedge hclk);
        end
        chk("stall_pulses", 64'(pulses - p0), 64'd0);
        chk("stall_cnt0", 64'(blk_cnt), 64'd0);
        s_valid = 1'b0; m_ready = 1'b1;
        @(negedge hclk);
        m_ready = 1'b0;
        chk("stall_cnt1", 64'(blk_cnt), 64'd1);
        chk("stall_idle", 64'({busy, s_ready}), 64'd1);

        // 5: reset during WAIT, late completion ignored
        do_cfg(64'hFEDCBA9876543210, 1'b1, 1'b0);
        cop_lat = 10;
        @(negedge hclk);
        s_valid = 1'b1; s_data = PT;
        @(negedge hclk);
        s_valid = 1'b0;
        repeat (3) @(negedge hclk);
        chk("wait_busy", 64'({busy, cop_iv}), {1'b1, 64'hFEDCBA9876543210});
        hresetn = 1'b0;
        @(negedge hclk);
        chk("midrst_flags", 64'({busy, s_ready, m_valid, cop_din_valid, err}), 64'b01000);
        chk("midrst_data", m_data | cop_din | cop_iv, 64'd0);
        chk("midrst_regs", 64'({blk_cnt, cop_encrypt, cop_mode_sel, cop_iv_sel}), 64'd0);
        hresetn = 1'b1;
        n = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge hclk);
            if (busy || m_valid) n++;
        end
        chk("late_dout_ignored", 64'(n), 64'd0);
        cop_lat = 4;

`ifdef DES_CTRL_TIMEOUT_EN
        // 6: completion never arrives
        do_cfg(64'd0, 1'b0, 1'b0);
        cop_mute = 1'b1;
        @(negedge hclk);
        s_valid = 1'b1; s_data = PT;
        @(negedge hclk);
        s_valid = 1'b0;
        n = 0;
        p0 = 0;
        while (busy && n < 200) begin
            if (m_valid) p0++;
            n++;
            @(negedge hclk);
        end
        chk("tmo_cycles", 64'(n), 64'd65);
        chk("tmo_err", 64'({err, busy, m_valid}), 64'b100);
        chk("tmo_no_out", 64'(p0), 64'd0);
        chk("tmo_cnt", 64'(blk_cnt), 64'd0);
        cop_mute = 1'b0;
        do_cfg(64'd0, 1'b0, 1'b0);
        chk("tmo_clear", 64'(err), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
